// File: rtl/window_buffer_15x15.sv
// Sliding 15x15 pixel window fed one 15-pixel column per valid cycle; exposes the inner
// 13x13 pixels row-major and flags complete windows and the last window of each frame.
module window_buffer_15x15 #(
    parameter int COLS = 17,
    parameter int ROWS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i,
    input  logic [7:0] S9_i, S10_i, S11_i, S12_i, S13_i, S14_i, S15_i,
    output logic [7:0] S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o, S10_o, S11_o, S12_o, S13_o,
    output logic [7:0] S14_o, S15_o, S16_o, S17_o, S18_o, S19_o, S20_o, S21_o, S22_o, S23_o, S24_o, S25_o, S26_o,
    output logic [7:0] S27_o, S28_o, S29_o, S30_o, S31_o, S32_o, S33_o, S34_o, S35_o, S36_o, S37_o, S38_o, S39_o,
    output logic [7:0] S40_o, S41_o, S42_o, S43_o, S44_o, S45_o, S46_o, S47_o, S48_o, S49_o, S50_o, S51_o, S52_o,
    output logic [7:0] S53_o, S54_o, S55_o, S56_o, S57_o, S58_o, S59_o, S60_o, S61_o, S62_o, S63_o, S64_o, S65_o,
    output logic [7:0] S66_o, S67_o, S68_o, S69_o, S70_o, S71_o, S72_o, S73_o, S74_o, S75_o, S76_o, S77_o, S78_o,
    output logic [7:0] S79_o, S80_o, S81_o, S82_o, S83_o, S84_o, S85_o, S86_o, S87_o, S88_o, S89_o, S90_o, S91_o,
    output logic [7:0] S92_o, S93_o, S94_o, S95_o, S96_o, S97_o, S98_o, S99_o, S100_o, S101_o, S102_o, S103_o, S104_o,
    output logic [7:0] S105_o, S106_o, S107_o, S108_o, S109_o, S110_o, S111_o, S112_o, S113_o, S114_o, S115_o, S116_o, S117_o,
    output logic [7:0] S118_o, S119_o, S120_o, S121_o, S122_o, S123_o, S124_o, S125_o, S126_o, S127_o, S128_o, S129_o, S130_o,
    output logic [7:0] S131_o, S132_o, S133_o, S134_o, S135_o, S136_o, S137_o, S138_o, S139_o, S140_o, S141_o, S142_o, S143_o,
    output logic [7:0] S144_o, S145_o, S146_o, S147_o, S148_o, S149_o, S150_o, S151_o, S152_o, S153_o, S154_o, S155_o, S156_o,
    output logic [7:0] S157_o, S158_o, S159_o, S160_o, S161_o, S162_o, S163_o, S164_o, S165_o, S166_o, S167_o, S168_o, S169_o,
    output logic       done_o,
    output logic       progress_done_o
);
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS - 13);

    logic [DATA_W-1:0] col_in [15];
    logic [DATA_W-1:0] win_q  [15][15];
    logic [DATA_W-1:0] win_d  [15][15];
    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic              done_q, done_d;
    logic              prog_q, prog_d;
    logic              last_col, last_row;

    assign col_in[0]  = S1_i;  assign col_in[1]  = S2_i;  assign col_in[2]  = S3_i;
    assign col_in[3]  = S4_i;  assign col_in[4]  = S5_i;  assign col_in[5]  = S6_i;
    assign col_in[6]  = S7_i;  assign col_in[7]  = S8_i;  assign col_in[8]  = S9_i;
    assign col_in[9]  = S10_i; assign col_in[10] = S11_i; assign col_in[11] = S12_i;
    assign col_in[12] = S13_i; assign col_in[13] = S14_i; assign col_in[14] = S15_i;

    assign last_col = (col_cnt_q == CW'(COLS - 1));
    assign last_row = (row_cnt_q == RW'(ROWS - 15));

    always_comb begin
        win_d     = win_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        done_d    = 1'b0;
        prog_d    = 1'b0;
        if (done_i) begin
            for (int r = 0; r < 15; r++) begin
                for (int c = 0; c < 14; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][14] = col_in[r];
            end
            // A window is complete once the accepted column is at least the 15th of its row.
            done_d = (col_cnt_q >= CW'(14));
            prog_d = last_col && last_row;
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 15; r++) begin
                for (int c = 0; c < 15; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            done_q    <= 1'b0;
            prog_q    <= 1'b0;
        end else begin
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            done_q    <= done_d;
            prog_q    <= prog_d;
        end
    end

    assign done_o          = done_q;
    assign progress_done_o = prog_q;

    // Inner 13x13: border rows 0/14 and columns 0/14 stay internal.
    assign S1_o   = win_q[1][1];   assign S2_o   = win_q[1][2];   assign S3_o   = win_q[1][3];   assign S4_o   = win_q[1][4];   assign S5_o   = win_q[1][5];
    assign S6_o   = win_q[1][6];   assign S7_o   = win_q[1][7];   assign S8_o   = win_q[1][8];   assign S9_o   = win_q[1][9];   assign S10_o  = win_q[1][10];
    assign S11_o  = win_q[1][11];  assign S12_o  = win_q[1][12];  assign S13_o  = win_q[1][13];
    assign S14_o  = win_q[2][1];   assign S15_o  = win_q[2][2];   assign S16_o  = win_q[2][3];   assign S17_o  = win_q[2][4];   assign S18_o  = win_q[2][5];
    assign S19_o  = win_q[2][6];   assign S20_o  = win_q[2][7];   assign S21_o  = win_q[2][8];   assign S22_o  = win_q[2][9];   assign S23_o  = win_q[2][10];
    assign S24_o  = win_q[2][11];  assign S25_o  = win_q[2][12];  assign S26_o  = win_q[2][13];
    assign S27_o  = win_q[3][1];   assign S28_o  = win_q[3][2];   assign S29_o  = win_q[3][3];   assign S30_o  = win_q[3][4];   assign S31_o  = win_q[3][5];
    assign S32_o  = win_q[3][6];   assign S33_o  = win_q[3][7];   assign S34_o  = win_q[3][8];   assign S35_o  = win_q[3][9];   assign S36_o  = win_q[3][10];
    assign S37_o  = win_q[3][11];  assign S38_o  = win_q[3][12];  assign S39_o  = win_q[3][13];
    assign S40_o  = win_q[4][1];   assign S41_o  = win_q[4][2];   assign S42_o  = win_q[4][3];   assign S43_o  = win_q[4][4];   assign S44_o  = win_q[4][5];
    assign S45_o  = win_q[4][6];   assign S46_o  = win_q[4][7];   assign S47_o  = win_q[4][8];   assign S48_o  = win_q[4][9];   assign S49_o  = win_q[4][10];
    assign S50_o  = win_q[4][11];  assign S51_o  = win_q[4][12];  assign S52_o  = win_q[4][13];
    assign S53_o  = win_q[5][1];   assign S54_o  = win_q[5][2];   assign S55_o  = win_q[5][3];   assign S56_o  = win_q[5][4];   assign S57_o  = win_q[5][5];
    assign S58_o  = win_q[5][6];   assign S59_o  = win_q[5][7];   assign S60_o  = win_q[5][8];   assign S61_o  = win_q[5][9];   assign S62_o  = win_q[5][10];
    assign S63_o  = win_q[5][11];  assign S64_o  = win_q[5][12];  assign S65_o  = win_q[5][13];
    assign S66_o  = win_q[6][1];   assign S67_o  = win_q[6][2];   assign S68_o  = win_q[6][3];   assign S69_o  = win_q[6][4];   assign S70_o  = win_q[6][5];
    assign S71_o  = win_q[6][6];   assign S72_o  = win_q[6][7];   assign S73_o  = win_q[6][8];   assign S74_o  = win_q[6][9];   assign S75_o  = win_q[6][10];
    assign S76_o  = win_q[6][11];  assign S77_o  = win_q[6][12];  assign S78_o  = win_q[6][13];
    assign S79_o  = win_q[7][1];   assign S80_o  = win_q[7][2];   assign S81_o  = win_q[7][3];   assign S82_o  = win_q[7][4];   assign S83_o  = win_q[7][5];
    assign S84_o  = win_q[7][6];   assign S85_o  = win_q[7][7];   assign S86_o  = win_q[7][8];   assign S87_o  = win_q[7][9];   assign S88_o  = win_q[7][10];
    assign S89_o  = win_q[7][11];  assign S90_o  = win_q[7][12];  assign S91_o  = win_q[7][13];
    assign S92_o  = win_q[8][1];   assign S93_o  = win_q[8][2];   assign S94_o  = win_q[8][3];   assign S95_o  = win_q[8][4];   assign S96_o  = win_q[8][5];
    assign S97_o  = win_q[8][6];   assign S98_o  = win_q[8][7];   assign S99_o  = win_q[8][8];   assign S100_o = win_q[8][9];   assign S101_o = win_q[8][10];
    assign S102_o = win_q[8][11];  assign S103_o = win_q[8][12];  assign S104_o = win_q[8][13];
    assign S105_o = win_q[9][1];   assign S106_o = win_q[9][2];   assign S107_o = win_q[9][3];   assign S108_o = win_q[9][4];   assign S109_o = win_q[9][5];
    assign S110_o = win_q[9][6];   assign S111_o = win_q[9][7];   assign S112_o = win_q[9][8];   assign S113_o = win_q[9][9];   assign S114_o = win_q[9][10];
    assign S115_o = win_q[9][11];  assign S116_o = win_q[9][12];  assign S117_o = win_q[9][13];
    assign S118_o = win_q[10][1];  assign S119_o = win_q[10][2];  assign S120_o = win_q[10][3];  assign S121_o = win_q[10][4];  assign S122_o = win_q[10][5];
    assign S123_o = win_q[10][6];  assign S124_o = win_q[10][7];  assign S125_o = win_q[10][8];  assign S126_o = win_q[10][9];  assign S127_o = win_q[10][10];
    assign S128_o = win_q[10][11]; assign S129_o = win_q[10][12]; assign S130_o = win_q[10][13];
    assign S131_o = win_q[11][1];  assign S132_o = win_q[11][2];  assign S133_o = win_q[11][3];  assign S134_o = win_q[11][4];  assign S135_o = win_q[11][5];
    assign S136_o = win_q[11][6];  assign S137_o = win_q[11][7];  assign S138_o = win_q[11][8];  assign S139_o = win_q[11][9];  assign S140_o = win_q[11][10];
    assign S141_o = win_q[11][11]; assign S142_o = win_q[11][12]; assign S143_o = win_q[11][13];
    assign S144_o = win_q[12][1];  assign S145_o = win_q[12][2];  assign S146_o = win_q[12][3];  assign S147_o = win_q[12][4];  assign S148_o = win_q[12][5];
    assign S149_o = win_q[12][6];  assign S150_o = win_q[12][7];  assign S151_o = win_q[12][8];  assign S152_o = win_q[12][9];  assign S153_o = win_q[12][10];
    assign S154_o = win_q[12][11]; assign S155_o = win_q[12][12]; assign S156_o = win_q[12][13];
    assign S157_o = win_q[13][1];  assign S158_o = win_q[13][2];  assign S159_o = win_q[13][3];  assign S160_o = win_q[13][4];  assign S161_o = win_q[13][5];
    assign S162_o = win_q[13][6];  assign S163_o = win_q[13][7];  assign S164_o = win_q[13][8];  assign S165_o = win_q[13][9];  assign S166_o = win_q[13][10];
    assign S167_o = win_q[13][11]; assign S168_o = win_q[13][12]; assign S169_o = win_q[13][13];

endmodule

// File: tb/tb_window_buffer_15x15.sv
// Bench for window_buffer_15x15: keeps the history of accepted columns and derives the
// expected window and flags from the column index arithmetic of the frame.
module tb_window_buffer_15x15;
    localparam int COLS = 17;
    localparam int ROWS = 17;

    typedef logic [14:0][7:0] col_t;

    logic       clk;
    logic       rst;
    logic       done_i;
    logic [7:0] s_in  [1:15];
    logic [7:0] s_out [1:169];
    logic       done_o;
    logic       progress_done_o;

    int   checks = 0;
    int   errors = 0;
    col_t hist[$];
    int   n_acc  = 0;
    logic exp_done = 1'b0;
    logic exp_prog = 1'b0;

    window_buffer_15x15 #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .done_i(done_i),
        .S1_i(s_in[1]), .S2_i(s_in[2]), .S3_i(s_in[3]), .S4_i(s_in[4]), .S5_i(s_in[5]),
        .S6_i(s_in[6]), .S7_i(s_in[7]), .S8_i(s_in[8]), .S9_i(s_in[9]), .S10_i(s_in[10]),
        .S11_i(s_in[11]), .S12_i(s_in[12]), .S13_i(s_in[13]), .S14_i(s_in[14]), .S15_i(s_in[15]),
        .S1_o(s_out[1]), .S2_o(s_out[2]), .S3_o(s_out[3]), .S4_o(s_out[4]), .S5_o(s_out[5]), .S6_o(s_out[6]), .S7_o(s_out[7]),
        .S8_o(s_out[8]), .S9_o(s_out[9]), .S10_o(s_out[10]), .S11_o(s_out[11]), .S12_o(s_out[12]), .S13_o(s_out[13]), .S14_o(s_out[14]),
        .S15_o(s_out[15]), .S16_o(s_out[16]), .S17_o(s_out[17]), .S18_o(s_out[18]), .S19_o(s_out[19]), .S20_o(s_out[20]), .S21_o(s_out[21]),
        .S22_o(s_out[22]), .S23_o(s_out[23]), .S24_o(s_out[24]), .S25_o(s_out[25]), .S26_o(s_out[26]), .S27_o(s_out[27]), .S28_o(s_out[28]),
        .S29_o(s_out[29]), .S30_o(s_out[30]), .S31_o(s_out[31]), .S32_o(s_out[32]), .S33_o(s_out[33]), .S34_o(s_out[34]), .S35_o(s_out[35]),
        .S36_o(s_out[36]), .S37_o(s_out[37]), .S38_o(s_out[38]), .S39_o(s_out[39]), .S40_o(s_out[40]), .S41_o(s_out[41]), .S42_o(s_out[42]),
        .S43_o(s_out[43]), .S44_o(s_out[44]), .S45_o(s_out[45]), .S46_o(s_out[46]), .S47_o(s_out[47]), .S48_o(s_out[48]), .S49_o(s_out[49]),
        .S50_o(s_out[50]), .S51_o(s_out[51]), .S52_o(s_out[52]), .S53_o(s_out[53]), .S54_o(s_out[54]), .S55_o(s_out[55]), .S56_o(s_out[56]),
        .S57_o(s_out[57]), .S58_o(s_out[58]), .S59_o(s_out[59]), .S60_o(s_out[60]), .S61_o(s_out[61]), .S62_o(s_out[62]), .S63_o(s_out[63]),
        .S64_o(s_out[64]), .S65_o(s_out[65]), .S66_o(s_out[66]), .S67_o(s_out[67]), .S68_o(s_out[68]), .S69_o(s_out[69]), .S70_o(s_out[70]),
        .S71_o(s_out[71]), .S72_o(s_out[72]), .S73_o(s_out[73]), .S74_o(s_out[74]), .S75_o(s_out[75]), .S76_o(s_out[76]), .S77_o(s_out[77]),
        .S78_o(s_out[78]), .S79_o(s_out[79]), .S80_o(s_out[80]), .S81_o(s_out[81]), .S82_o(s_out[82]), .S83_o(s_out[83]), .S84_o(s_out[84]),
        .S85_o(s_out[85]), .S86_o(s_out[86]), .S87_o(s_out[87]), .S88_o(s_out[88]), .S89_o(s_out[89]), .S90_o(s_out[90]), .S91_o(s_out[91]),
        .S92_o(s_out[92]), .S93_o(s_out[93]), .S94_o(s_out[94]), .S95_o(s_out[95]), .S96_o(s_out[96]), .S97_o(s_out[97]), .S98_o(s_out[98]),
        .S99_o(s_out[99]), .S100_o(s_out[100]), .S101_o(s_out[101]), .S102_o(s_out[102]), .S103_o(s_out[103]), .S104_o(s_out[104]), .S105_o(s_out[105]),
        .S106_o(s_out[106]), .S107_o(s_out[107]), .S108_o(s_out[108]), .S109_o(s_out[109]), .S110_o(s_out[110]), .S111_o(s_out[111]), .S112_o(s_out[112]),
        .S113_o(s_out[113]), .S114_o(s_out[114]), .S115_o(s_out[115]), .S116_o(s_out[116]), .S117_o(s_out[117]), .S118_o(s_out[118]), .S119_o(s_out[119]),
        .S120_o(s_out[120]), .S121_o(s_out[121]), .S122_o(s_out[122]), .S123_o(s_out[123]), .S124_o(s_out[124]), .S125_o(s_out[125]), .S126_o(s_out[126]),
        .S127_o(s_out[127]), .S128_o(s_out[128]), .S129_o(s_out[129]), .S130_o(s_out[130]), .S131_o(s_out[131]), .S132_o(s_out[132]), .S133_o(s_out[133]),
        .S134_o(s_out[134]), .S135_o(s_out[135]), .S136_o(s_out[136]), .S137_o(s_out[137]), .S138_o(s_out[138]), .S139_o(s_out[139]), .S140_o(s_out[140]),
        .S141_o(s_out[141]), .S142_o(s_out[142]), .S143_o(s_out[143]), .S144_o(s_out[144]), .S145_o(s_out[145]), .S146_o(s_out[146]), .S147_o(s_out[147]),
        .S148_o(s_out[148]), .S149_o(s_out[149]), .S150_o(s_out[150]), .S151_o(s_out[151]), .S152_o(s_out[152]), .S153_o(s_out[153]), .S154_o(s_out[154]),
        .S155_o(s_out[155]), .S156_o(s_out[156]), .S157_o(s_out[157]), .S158_o(s_out[158]), .S159_o(s_out[159]), .S160_o(s_out[160]), .S161_o(s_out[161]),
        .S162_o(s_out[162]), .S163_o(s_out[163]), .S164_o(s_out[164]), .S165_o(s_out[165]), .S166_o(s_out[166]), .S167_o(s_out[167]), .S168_o(s_out[168]),
        .S169_o(s_out[169]),
        .done_o(done_o), .progress_done_o(progress_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Window column c holds the column accepted (14-c) accepts ago; zero before that.
    function automatic logic [7:0] exp_pix(int r, int c);
        int idx;
        idx = hist.size() - 1 - (14 - c);
        if (idx < 0) return 8'd0;
        return hist[idx][r];
    endfunction

    task automatic model_reset();
        hist.delete();
        n_acc    = 0;
        exp_done = 1'b0;
        exp_prog = 1'b0;
    endtask

    task automatic check_all();
        chk("done_o", {31'd0, done_o}, {31'd0, exp_done});
        chk("progress_done_o", {31'd0, progress_done_o}, {31'd0, exp_prog});
        for (int r = 1; r <= 13; r++) begin
            for (int c = 1; c <= 13; c++) begin
                chk($sformatf("S%0d_o", (r - 1) * 13 + c), {24'd0, s_out[(r - 1) * 13 + c]}, {24'd0, exp_pix(r, c)});
            end
        end
    endtask

    task automatic cyc(input logic dv, input col_t col);
        int k;
        done_i = dv;
        for (int r = 0; r < 15; r++) s_in[r + 1] = col[r];
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        exp_prog = 1'b0;
        if (rst && dv) begin
            k = n_acc;
            n_acc++;
            hist.push_back(col);
            if (hist.size() > 15) void'(hist.pop_front());
            exp_done = ((k % COLS) >= 14);
            exp_prog = ((k % COLS) == COLS - 1) && (((k / COLS) % (ROWS - 14)) == ROWS - 15);
        end
        check_all();
    endtask

    function automatic col_t rand_col();
        col_t c;
        for (int r = 0; r < 15; r++) c[r] = 8'($urandom_range(0, 255));
        return c;
    endfunction

    function automatic col_t flat_col(int v);
        col_t c;
        for (int r = 0; r < 15; r++) c[r] = 8'(v);
        return c;
    endfunction

    initial begin
        int win_cnt;
        col_t c;
        rst    = 1'b0;
        done_i = 1'b0;
        for (int r = 1; r <= 15; r++) s_in[r] = 8'd0;
        model_reset();

        // Held in reset with toggling inputs: everything stays cleared.
        for (int i = 0; i < 4; i++) cyc(1'($urandom_range(0, 1)), rand_col());
        rst = 1'b1;

        // Flat fill stream: column value i on every row.
        win_cnt = 0;
        for (int i = 1; i <= 70; i++) begin
            cyc(1'b1, flat_col(i));
            if (i <= 51 && done_o) win_cnt++;
            if (i == 14) chk("fill_done_early", {31'd0, done_o}, 32'd0);
            if (i == 15) begin
                chk("fill_done_first", {31'd0, done_o}, 32'd1);
                chk("fill_S1", {24'd0, s_out[1]}, 32'd2);
                chk("fill_S13", {24'd0, s_out[13]}, 32'd14);
                chk("fill_S14", {24'd0, s_out[14]}, 32'd2);
                chk("fill_S169", {24'd0, s_out[169]}, 32'd14);
            end
            if (i == 18) chk("row_wrap_done", {31'd0, done_o}, 32'd0);
            if (i == 32) chk("row1_done", {31'd0, done_o}, 32'd1);
            if (i == 50) chk("prog_early", {31'd0, progress_done_o}, 32'd0);
            if (i == 51) chk("frame_end_prog", {31'd0, progress_done_o}, 32'd1);
            if (i == 66) chk("frame2_first_done", {31'd0, done_o}, 32'd1);
        end
        chk("frame_win_cnt", 32'(win_cnt), 32'd9);

        // Distinct rows with a 5-cycle stall inside a window run.
        for (int j = 0; j < 40; j++) begin
            for (int r = 0; r < 15; r++) c[r] = 8'(16 * (r + 1) + j);
            cyc(1'b1, c);
            if (j == 20) begin
                for (int s = 0; s < 5; s++) cyc(1'b0, rand_col());
            end
        end

        // Random valid pattern and pixels.
        for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 3) != 0), rand_col());

        // Asynchronous clear between edges, then restart from column 0, row 0.
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) cyc(1'b1, rand_col());
        rst = 1'b1;
        for (int i = 0; i < 80; i++) cyc(1'($urandom_range(0, 4) != 0), rand_col());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
